ac_alu_exec: RTL

//  Accumulator execute stage of the complex CPU: holds AC and runs ALU ops on AC and a memory operand.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/shift_add_mul.sv | 44 ++++
 rtl/ac_alu_exec.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the accumulator execute stage.
package cpu_pkg;

    localparam int W       = 12;
    localparam int MUL_CYC = 12;

    typedef enum logic [3:0] {
        OP_LDA = 4'b0001,
        OP_CMP = 4'b0100,
        OP_ADD = 4'b1001,
        OP_SUB = 4'b1010,
        OP_AND = 4'b1011,
        OP_OR  = 4'b1100,
        OP_MUL = 4'b1101
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        MUL_LOOP = 2'd2,
        DONE     = 2'd3
    } exec_state_t;

    // Ops whose result feeds the downstream NZCV flag logic.
    function automatic logic sets_flags(input logic [3:0] opc);
        return (opc == OP_CMP) || (opc == OP_ADD) || (opc == OP_SUB);
    endfunction

endpackage

// File: rtl/shift_add_mul.sv
// Iterative W x W -> W shift-add multiplier: load captures operands, each step
// consumes one multiplier bit. result is the accumulator including the current step.
module shift_add_mul #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         step,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [3:0]   count,
    output logic [W-1:0] result
);

    logic [W-1:0] acc_r;
    logic [W-1:0] mcand_r;
    logic [W-1:0] mplier_r;
    logic [3:0]   count_r;

    assign result = mplier_r[0] ? (acc_r + mcand_r) : acc_r;
    assign count  = count_r;

    // Operand load and one shift-add iteration per step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r    <= {W{1'b0}};
            mcand_r  <= {W{1'b0}};
            mplier_r <= {W{1'b0}};
            count_r  <= 4'd0;
        end else if (load) begin
            acc_r    <= {W{1'b0}};
            mcand_r  <= a;
            mplier_r <= b;
            count_r  <= 4'd0;
        end else if (step) begin
            acc_r    <= result;
            mcand_r  <= mcand_r << 1;
            mplier_r <= mplier_r >> 1;
            count_r  <= count_r + 4'd1;
        end
    end

endmodule

// File: rtl/ac_alu_exec.sv
// Accumulator execute stage: holds AC, runs ALU ops on AC and a memory operand.
// Define AC_ALU_MUL_EN to build the iterative MUL; otherwise 1101 is illegal.
module ac_alu_exec #(
    parameter int W       = cpu_pkg::W,
    parameter int MUL_CYC = cpu_pkg::MUL_CYC
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [3:0]   opcode_in,
    input  logic [W-1:0] operand,
    output logic         busy,
    output logic         done,
    output logic         illegal_op,
    output logic [W-1:0] AC,
    output logic [W-1:0] AC_result,
    output logic [W-1:0] op1,
    output logic [W-1:0] op2,
    output logic [3:0]   opcode,
    output logic         AC_update
);
    import cpu_pkg::*;

    exec_state_t  state_r;
    exec_state_t  state_nxt_s;
    logic [W-1:0] alu_val_s;
    logic         alu_wr_ac_s;
    logic         alu_wr_res_s;
    logic         legal_s;
    logic         enter_done_s;

`ifdef AC_ALU_MUL_EN
    localparam logic [3:0] MUL_LAST = 4'(MUL_CYC - 1);
    logic         mul_load_s;
    logic         mul_step_s;
    logic [3:0]   mul_count_s;
    logic [W-1:0] mul_result_s;

    assign mul_load_s = (state_r == EXEC) && (opcode == OP_MUL);
    assign mul_step_s = (state_r == MUL_LOOP);

    shift_add_mul #(.W(W)) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (mul_load_s),
        .step   (mul_step_s),
        .a      (op1),
        .b      (op2),
        .count  (mul_count_s),
        .result (mul_result_s)
    );
`endif

    // Single-cycle ALU evaluated on the accept edge so AC_result settles a cycle before AC_update.
    always_comb begin
        alu_val_s    = {W{1'b0}};
        alu_wr_ac_s  = 1'b0;
        alu_wr_res_s = 1'b0;
        case (opcode_in)
            OP_LDA: begin alu_val_s = operand;      alu_wr_ac_s = 1'b1; alu_wr_res_s = 1'b1; end
            OP_CMP: begin alu_val_s = AC - operand;                     alu_wr_res_s = 1'b1; end
            OP_ADD: begin alu_val_s = AC + operand; alu_wr_ac_s = 1'b1; alu_wr_res_s = 1'b1; end
            OP_SUB: begin alu_val_s = AC - operand; alu_wr_ac_s = 1'b1; alu_wr_res_s = 1'b1; end
            OP_AND: begin alu_val_s = AC & operand; alu_wr_ac_s = 1'b1; alu_wr_res_s = 1'b1; end
            OP_OR:  begin alu_val_s = AC | operand; alu_wr_ac_s = 1'b1; alu_wr_res_s = 1'b1; end
            default: begin alu_val_s = {W{1'b0}}; alu_wr_ac_s = 1'b0; alu_wr_res_s = 1'b0; end
        endcase
    end

    // Legality of the captured opcode.
    always_comb begin
        legal_s = 1'b0;
        case (opcode)
            OP_LDA, OP_CMP, OP_ADD, OP_SUB, OP_AND, OP_OR: legal_s = 1'b1;
`ifdef AC_ALU_MUL_EN
            OP_MUL: legal_s = 1'b1;
`endif
            default: legal_s = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_nxt_s = EXEC;
                else       state_nxt_s = IDLE;
            end
            EXEC: begin
`ifdef AC_ALU_MUL_EN
                if (opcode == OP_MUL) state_nxt_s = MUL_LOOP;
                else                  state_nxt_s = DONE;
`else
                state_nxt_s = DONE;
`endif
            end
`ifdef AC_ALU_MUL_EN
            MUL_LOOP: begin
                if (mul_count_s == MUL_LAST) state_nxt_s = DONE;
                else                         state_nxt_s = MUL_LOOP;
            end
`endif
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    assign enter_done_s = (state_nxt_s == DONE) && (state_r != DONE);

    // Capture registers, AC, result bus and handshake pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy       <= 1'b0;
            done       <= 1'b0;
            illegal_op <= 1'b0;
            AC_update  <= 1'b0;
            AC         <= {W{1'b0}};
            AC_result  <= {W{1'b0}};
            op1        <= {W{1'b0}};
            op2        <= {W{1'b0}};
            opcode     <= 4'd0;
        end else begin
            done       <= enter_done_s;
            illegal_op <= enter_done_s && (state_r == EXEC) && !legal_s;
            AC_update  <= enter_done_s && (state_r == EXEC) && legal_s && sets_flags(opcode);
            if ((state_r == IDLE) && start) begin
                busy   <= 1'b1;
                op1    <= AC;
                op2    <= operand;
                opcode <= opcode_in;
                if (alu_wr_ac_s)  AC        <= alu_val_s;
                if (alu_wr_res_s) AC_result <= alu_val_s;
            end
            if (state_r == DONE) busy <= 1'b0;
`ifdef AC_ALU_MUL_EN
            if ((state_r == MUL_LOOP) && (state_nxt_s == DONE)) begin
                AC        <= mul_result_s;
                AC_result <= mul_result_s;
            end
`endif
        end
    end

endmodule
